// File: rtl/mmio_snapshot_master.sv
// mmio_snapshot_master: copies frame count and player state into dmem each frame tick, then verifies it
module mmio_snapshot_master #(
    parameter logic [11:0] BASE_ADDR = 12'h800,
    parameter int          NUM_WORDS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [31:0] pos1,
    input  logic [31:0] pos2,
    input  logic [31:0] damage1,
    input  logic [31:0] damage2,
    input  logic        cpu_access,
    input  logic [12:0] cpu_address,
    input  logic [31:0] cpu_data_in,
    input  logic        cpu_wren,
    output logic [12:0] address,
    output logic [31:0] data_in,
    output logic        wren,
    input  logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        mismatch,
    output logic [31:0] frame_count,
    output logic [7:0]  overrun_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LATCH = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] LAST  = 3'(NUM_WORDS - 1);

    logic [2:0]  state;
    logic [2:0]  idx;
    logic        pend;
    logic [31:0] snap [NUM_WORDS];
    logic        tick;
    logic        last;

    // the CPU owns the bus whenever it asks; otherwise the master drives its current word
    always_comb begin
        tick    = frame_tick & enable;
        last    = idx == LAST;
        busy    = state != IDLE;
        address = cpu_access ? cpu_address : {1'b0, BASE_ADDR + {9'd0, idx}};
        data_in = cpu_access ? cpu_data_in : snap[idx];
        wren    = cpu_access ? cpu_wren : state == WRITE;
    end

    // capture live values at LATCH; word 0 is the count this snapshot will publish
    always_ff @(posedge clock) begin
        if (state == LATCH) begin
            snap[0] <= frame_count + 32'd1;
            snap[1] <= pos1;
            snap[2] <= pos2;
            snap[3] <= damage1;
            snap[4] <= damage2;
        end
    end

    // sequencer: latch, write all words, read them back, then publish; bus phases freeze on CPU access
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            pend          <= 1'b0;
            mismatch      <= 1'b0;
            done          <= 1'b0;
            frame_count   <= 32'd0;
            overrun_count <= 8'd0;
        end else begin
            done <= 1'b0;
            if (tick && pend && overrun_count != 8'hff)
                overrun_count <= overrun_count + 8'd1;
            if (state == IDLE)
                pend <= 1'b0;
            else if (tick)
                pend <= 1'b1;
            case (state)
                IDLE: if (pend || tick) state <= LATCH;
                LATCH: begin
                    idx      <= 3'd0;
                    mismatch <= 1'b0;
                    state    <= WRITE;
                end
                WRITE: if (!cpu_access) begin
                    idx <= last ? 3'd0 : idx + 3'd1;
                    if (last) state <= READ;
                end
                READ: if (!cpu_access) begin
                    if (data_out != snap[idx]) mismatch <= 1'b1;
                    idx <= last ? 3'd0 : idx + 3'd1;
                    if (last) begin
                        state <= CHECK;
                        done  <= 1'b1;
                    end
                end
                CHECK: begin
                    frame_count <= snap[0];
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
